bht_access_ctrl: RTL
====================

Name: bht_access_ctrl

Overview:
- Controller that sequences every access to a single-port branch history table (M entries × N-bit counters, 1-cycle read latency).
- Arbitrates two requesters:
  - the fetch-stage prediction lookup;
  - branch-resolution updates, buffered in a small queue and applied as read-modify-write.
- After reset, sweeps the table to a known initial value before admitting traffic.

Parameters:
- M, 64, number of table entries (power of 2); ADDR_BITS = $clog2(M).
- N, 2, counter bits per entry (1 or 2).
- PC_W, 9, PC width.
- UQ_DEPTH, 4, update-queue depth (power of 2).
- STARVE_LIM, 8, cycles an update may wait behind lookups before it gains priority.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_pc  in  PC_W  lookup PC.
- lk_ready  out  1  lookup granted this cycle (transfer when lk_valid && lk_ready).
- pred_valid  out  1  prediction valid; asserted the cycle after a lookup grant.
- pred_taken  out  1  predicted direction = tbl_rdata[N-1]; 0 when pred_valid=0.
- up_valid  in  1  resolved-branch update request.
- up_pc  in  PC_W  resolved PC.
- up_taken  in  1  actual outcome.
- up_ready  out  1  queue can accept an update.
- uq_count  out  $clog2(UQ_DEPTH)+1  queue occupancy.
- init_done  out  1  table sweep complete.
- tbl_en  out  1  table access strobe.
- tbl_we  out  1  table write enable.
- tbl_addr  out  ADDR_BITS  table index.
- tbl_wdata  out  N  table write data.
- tbl_rdata  in  N  table read data, valid the cycle after tbl_en && !tbl_we.

Behaviour:
- Index for both requesters = pc[ADDR_BITS-1:0].
- Reset (reset=0 at posedge clk):
  - state←INIT, init_idx←0, queue flushed (uq_count=0), starve_cnt←0.
  - init_done=0, pred_valid=0.
  - While reset is low: tbl_en=0, lk_ready=0, up_ready=0.
  - Reset mid-RMW aborts it; no write is issued.
- INIT state:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=init_idx, tbl_wdata=INIT_VAL, init_idx++.
  - INIT_VAL: N=2 → 2'b01 (weak not-taken); N=1 → 0.
  - After writing index M-1, go to IDLE; init_done=1 from the next cycle on.
  - lk_ready=0 and up_ready=0 throughout INIT.
- Update queue:
  - FIFO with wrapping pointers. up_ready = !full outside INIT.
  - Push on up_valid && up_ready. Push and pop in the same cycle are legal; occupancy is unchanged.
  - No push while full, even if a pop occurs that cycle.
- Priority (IDLE only):
  - upd_pri = full || (starve_cnt ≥ STARVE_LIM).
  - lk_ready = (state==IDLE) && !(upd_pri && !empty).
- Lookup grant (IDLE):
  - tbl_en=1, tbl_we=0, tbl_addr=lk index; state stays IDLE.
  - Next cycle: pred_valid=1 and pred_taken=tbl_rdata[N-1].
  - Back-to-back lookups: one per cycle.
- Update issue (IDLE, queue non-empty, no lookup grant):
  - Read the head index (tbl_en=1, tbl_we=0); go to UPD_WR.
- UPD_WR:
  - tbl_en=1, tbl_we=1, same address; tbl_wdata = f(tbl_rdata, head.taken).
  - N=2: saturating ±1 (taken increments to max 2'b11; not-taken decrements to min 2'b00).
  - N=1: tbl_wdata = taken.
  - Pop head, clear starve_cnt, return to IDLE. lk_ready=0 in UPD_WR.
- starve_cnt:
  - Increments, saturating, each IDLE cycle in which the queue is non-empty and a lookup is granted.
  - Cleared on update issue or when the queue is empty.
- Hazards:
  - No forwarding. A lookup to an index with a queued or in-flight update returns the pre-update table value.
  - Updates to the same index are applied in order.

Test Plan:
- Release reset → 64 cycles with tbl_we=1, tbl_addr 0..63, tbl_wdata=2'b01; init_done=1 on cycle 65; lk_ready=0 and up_ready=0 during the sweep.
- After init, lookup lk_pc=9'h1C5 (index 5), tbl model returns 01 → lk_ready=1 that cycle; next cycle pred_valid=1, pred_taken=0.
- Three updates to index 5, taken=1, no lookups → writes 2'b10, 2'b11, 2'b11 (saturated), each 2 cycles (read then write); then taken=0 on an entry holding 00 → writes 00.
- lk_valid held high continuously, one update pushed → lookups granted for 8 cycles, then lk_ready=0 for 2 cycles while the RMW runs; pred_valid drops in the cycle after each non-granted cycle.
- lk_valid held high, push 4 updates → up_ready=0 at uq_count=4; update issues immediately (full priority); up_ready returns to 1 after the first pop; a 5th push while full is not accepted.
- Assert reset during UPD_WR → no table write that cycle; uq_count=0; INIT restarts at addr 0; pred_valid=0.

Source files
------------

// File: rtl/bht_access_ctrl.sv
// Branch history table access controller.
// Sequences all accesses to a single-port BHT (1-cycle read latency):
// clears the table after reset, then arbitrates fetch-stage lookups
// against queued branch-resolution updates (read-modify-write).
// Lookups win unless the update queue is full or its head has waited
// STARVE_LIM granted-lookup cycles.
module bht_access_ctrl #(
    parameter int M          = 64,
    parameter int N          = 2,
    parameter int PC_W       = 9,
    parameter int UQ_DEPTH   = 4,
    parameter int STARVE_LIM = 8,
    localparam int ADDR_BITS = $clog2(M),
    localparam int CNT_W     = $clog2(UQ_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lk_valid,
    input  logic [PC_W-1:0]      lk_pc,
    output logic                 lk_ready,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 up_valid,
    input  logic [PC_W-1:0]      up_pc,
    input  logic                 up_taken,
    output logic                 up_ready,
    output logic [CNT_W-1:0]     uq_count,
    output logic                 init_done,
    output logic                 tbl_en,
    output logic                 tbl_we,
    output logic [ADDR_BITS-1:0] tbl_addr,
    output logic [N-1:0]         tbl_wdata,
    input  logic [N-1:0]         tbl_rdata
);

    localparam int PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_UPD_WR = 2'd2;

    // Weak not-taken for 2-bit counters, not-taken for 1-bit.
    localparam logic [N-1:0] INIT_VAL = (N == 2) ? N'(1) : N'(0);

    // Counter update: saturating +/-1 for multi-bit, direct outcome for 1-bit.
    function automatic logic [N-1:0] next_ctr(input logic [N-1:0] cur, input logic taken);
        logic [N-1:0] res;
        if (N == 1) begin
            res = N'(taken);
        end else if (taken && (cur != {N{1'b1}})) begin
            res = cur + N'(1);
        end else if (!taken && (cur != {N{1'b0}})) begin
            res = cur - N'(1);
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic [1:0]           state_r;
    logic [ADDR_BITS-1:0] init_idx_r;
    logic                 init_done_r;
    logic                 pred_valid_r;
    logic [SC_W-1:0]      starve_cnt_r;
    logic [CNT_W-1:0]     count_r;
    logic [PTR_W-1:0]     wptr_r;
    logic [PTR_W-1:0]     rptr_r;
    logic [ADDR_BITS-1:0] uq_idx_r [UQ_DEPTH];
    logic                 uq_tk_r  [UQ_DEPTH];

    logic                 empty_s;
    logic                 full_s;
    logic                 upd_pri_s;
    logic                 lk_ready_s;
    logic                 lk_grant_s;
    logic                 upd_issue_s;
    logic                 up_ready_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ADDR_BITS-1:0] head_idx_s;
    logic                 head_tk_s;
    logic                 unused_s;

    // Upper PC bits do not take part in indexing.
    assign unused_s = ^{lk_pc[PC_W-1:ADDR_BITS], up_pc[PC_W-1:ADDR_BITS]};

    // Arbitration and queue handshake decode.
    always_comb begin
        empty_s     = (count_r == CNT_W'(0));
        full_s      = (count_r == CNT_W'(UQ_DEPTH));
        upd_pri_s   = full_s || (starve_cnt_r >= SC_W'(STARVE_LIM));
        lk_ready_s  = reset && (state_r == ST_IDLE) && !(upd_pri_s && !empty_s);
        lk_grant_s  = lk_valid && lk_ready_s;
        upd_issue_s = reset && (state_r == ST_IDLE) && !empty_s && !lk_grant_s;
        up_ready_s  = reset && (state_r != ST_INIT) && !full_s;
        push_s      = up_valid && up_ready_s;
        pop_s       = reset && (state_r == ST_UPD_WR);
        head_idx_s  = uq_idx_r[rptr_r];
        head_tk_s   = uq_tk_r[rptr_r];
    end

    // Table port drive; nothing reaches the table while reset is held.
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = {ADDR_BITS{1'b0}};
        tbl_wdata = {N{1'b0}};
        if (!reset) begin
            tbl_en = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = init_idx_r;
                    tbl_wdata = INIT_VAL;
                end
                ST_IDLE: begin
                    if (lk_grant_s) begin
                        tbl_en   = 1'b1;
                        tbl_addr = lk_pc[ADDR_BITS-1:0];
                    end else if (upd_issue_s) begin
                        tbl_en   = 1'b1;
                        tbl_addr = head_idx_s;
                    end else begin
                        tbl_en = 1'b0;
                    end
                end
                ST_UPD_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = head_idx_s;
                    tbl_wdata = next_ctr(tbl_rdata, head_tk_s);
                end
                default: begin
                    tbl_en = 1'b0;
                end
            endcase
        end
    end

    // Controller state, sweep index and init completion flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_INIT;
            init_idx_r  <= {ADDR_BITS{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_idx_r <= init_idx_r + ADDR_BITS'(1);
                    if (init_idx_r == ADDR_BITS'(M - 1)) begin
                        state_r     <= ST_IDLE;
                        init_done_r <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (upd_issue_s) begin
                        state_r <= ST_UPD_WR;
                    end
                end
                ST_UPD_WR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Prediction is valid the cycle after a lookup grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_valid_r <= 1'b0;
        end else begin
            pred_valid_r <= lk_grant_s;
        end
    end

    // Starvation counter: counts lookups granted ahead of a waiting update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (empty_s || upd_issue_s) begin
                starve_cnt_r <= {SC_W{1'b0}};
            end else if (lk_grant_s && (starve_cnt_r < SC_W'(STARVE_LIM))) begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if (state_r == ST_UPD_WR) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Update queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Update queue storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < UQ_DEPTH; i++) begin
                uq_idx_r[i] <= {ADDR_BITS{1'b0}};
                uq_tk_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            uq_idx_r[wptr_r] <= up_pc[ADDR_BITS-1:0];
            uq_tk_r[wptr_r]  <= up_taken;
        end
    end

    assign lk_ready   = lk_ready_s;
    assign up_ready   = up_ready_s;
    assign uq_count   = count_r;
    assign init_done  = init_done_r;
    assign pred_valid = pred_valid_r;
    assign pred_taken = pred_valid_r & tbl_rdata[N-1];

endmodule
